// File: rtl/mips_multicycle_if.sv
// Memory bus between the multicycle core (master) and its memory (slave).
// A transfer is held stable from mem_req until mem_ack, which may arrive in the same cycle.
interface mips_multicycle_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: add/sub/and/or/slt, lw, sw, beq, addi, j over one shared memory bus.
// Illegal opcodes and memory timeouts park the core in HALT until reset.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    mips_multicycle_if.master        mem,
    input  logic [4:0]               rf_ra2,
    output logic [31:0]              rf_rd2,
    output logic [31:0]              pc,
    output logic [31:0]              retired,
    output logic                     error
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTEXEC, RTWB, IEXEC, IWB, BRANCH, JUMP, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t      state, next_state;
    logic [31:0] instr, a_reg, b_reg, addr_reg, data_reg, result;
    logic [31:0] wait_cnt;
    logic [31:0] rf [32];

    logic        req, bus_ack, timeout_hit;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = {{16{instr[15]}}, instr[15:0]};

    function automatic logic funct_ok(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic logic [31:0] alu(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            6'h25:   return x | y;
            6'h2A:   return {31'b0, $signed(x) < $signed(y)};
            default: return 32'b0;
        endcase
    endfunction

    // An ack only counts while a request is actually outstanding.
    assign bus_ack     = req && mem.mem_ack;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && req && !mem.mem_ack
                         && (wait_cnt == TIMEOUT_CYCLES - 1);
    assign error       = (state == HALT);
    assign rf_rd2      = (rf_ra2 == 5'd0) ? 32'b0 : rf[rf_ra2];

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            FETCH:   if (timeout_hit) next_state = HALT; else if (bus_ack) next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = funct_ok(funct) ? RTEXEC : HALT;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = IEXEC;
                    OP_J:         next_state = JUMP;
                    default:      next_state = HALT;
                endcase
            end
            MEMADR:  next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (timeout_hit) next_state = HALT; else if (bus_ack) next_state = MEMWB;
            MEMWR:   if (timeout_hit) next_state = HALT; else if (bus_ack) next_state = FETCH;
            RTEXEC:  next_state = RTWB;
            IEXEC:   next_state = IWB;
            MEMWB, RTWB, IWB, BRANCH, JUMP: next_state = FETCH;
            default: next_state = HALT;
        endcase
    end

    always_comb begin
        req           = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = pc;
        mem.mem_wdata = b_reg;
        case (state)
            FETCH:   req = 1'b1;
            MEMRD:   begin req = 1'b1; mem.mem_addr = addr_reg; end
            MEMWR:   begin req = 1'b1; mem.mem_we = 1'b1; mem.mem_addr = addr_reg; end
            default: ;
        endcase
        if (reset) begin
            req        = 1'b0;
            mem.mem_we = 1'b0;
        end
    end

    assign mem.mem_req = req;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            retired  <= 32'b0;
            wait_cnt <= 32'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (req && !mem.mem_ack) ? wait_cnt + 32'd1 : 32'b0;
            if (state != FETCH && next_state == FETCH)
                retired <= retired + 32'd1;
            case (state)
                FETCH:   if (bus_ack) pc <= pc + 32'd4;
                BRANCH:  if (a_reg == b_reg) pc <= pc + (imm_ext << 2);
                JUMP:    pc <= {pc[31:28], instr[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    // NOTE: datapath latches and the register file carry no reset; their contents are
    // only consumed after being written along the FSM path.
    always_ff @(posedge clock) begin
        case (state)
            FETCH:   if (bus_ack) instr <= mem.mem_rdata;
            DECODE: begin
                a_reg <= (rs == 5'd0) ? 32'b0 : rf[rs];
                b_reg <= (rt == 5'd0) ? 32'b0 : rf[rt];
            end
            MEMADR:  addr_reg <= a_reg + imm_ext;
            MEMRD:   if (bus_ack) data_reg <= mem.mem_rdata;
            RTEXEC:  result <= alu(funct, a_reg, b_reg);
            IEXEC:   result <= a_reg + imm_ext;
            default: ;
        endcase
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = result;
        case (state)
            MEMWB:   begin rf_we = 1'b1; rf_wd = data_reg; end
            RTWB:    begin rf_we = 1'b1; rf_wa = rd; end
            IWB:     rf_we = 1'b1;
            default: ;
        endcase
        if (rf_wa == 5'd0)
            rf_we = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (rf_we)
            rf[rf_wa] <= rf_wd;
    end

endmodule
